alu_bist_driver: RTL and testbench
==================================

Name: alu_bist_driver

Overview:
- On-chip stimulus generator and response compactor that drives the 4-bit ALU's operand/opcode inputs and captures its result port.
- Lets silicon self-check the ALU without external pattern equipment.
- Generates pseudo-random operand/opcode vectors from a 16-bit Galois LFSR and folds each ALU result into a 16-bit MISR signature.
- Flags pass/fail against a golden signature; sits beside tt_um_ALU inside the same top-level tile.

Parameters:
- NUM_VECTORS, 256: vectors per run; legal range 1..65535.
- SETTLE_CYCLES, 1: cycles each vector is held before its result is sampled; legal range 1..15.
- LFSR_SEED, 16'hACE1: LFSR load value at reset and at run start; must be nonzero.
- GOLDEN_SIG, 16'h0000: expected final MISR value.

Ports:
- clk  input  1  tile clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ena  input  1  tile enable; low freezes all state.
- start  input  1  level; sampled in IDLE or DONE to begin a run.
- dut_result  input  8  ALU result (uo_out of the ALU).
- stim_a  output  4  operand A = lfsr[3:0].
- stim_b  output  4  operand B = lfsr[7:4].
- stim_op  output  3  opcode = lfsr[10:8].
- busy  output  1  high in SETTLE/CAPTURE.
- done  output  1  high in DONE.
- pass  output  1  registered (misr == GOLDEN_SIG), valid while done=1, else 0.
- signature  output  16  current MISR value.

Interface rule: one clock (clk); reset rst_n is asynchronous and active-low.

Behaviour:
- Reset values: state=IDLE, lfsr=LFSR_SEED, misr=0, vec_cnt=0, settle_cnt=0, busy=0, done=0, pass=0.
- Reset outputs with default seed: stim_a=1, stim_b=E, stim_op=4, signature=0.
- Galois step g(x) = x[0] ? (x>>1)^16'hB400 : (x>>1). The same function serves the LFSR and the MISR.
- stim_* are wired directly from lfsr register bits, so there is no combinational path from inputs.
- State machine (all transitions gated by ena=1; ena=0 holds every register):
  - IDLE: start=1 -> lfsr=LFSR_SEED, misr=0, vec_cnt=0, settle_cnt=0, go to SETTLE.
  - SETTLE: settle_cnt increments; when settle_cnt==SETTLE_CYCLES-1, go to CAPTURE.
  - CAPTURE (1 cycle):
    - misr <= g(misr) ^ {8'h00, dut_result}.
    - lfsr <= g(lfsr); settle_cnt=0.
    - If vec_cnt==NUM_VECTORS-1, go to DONE and register pass from the updated misr.
    - Otherwise vec_cnt++ and return to SETTLE.
  - DONE: done=1, with pass and signature held. start=1 restarts exactly as from IDLE. pass is cleared on leaving DONE.
- Timing:
  - Each vector is presented for SETTLE_CYCLES+1 cycles; dut_result is sampled at the CAPTURE edge.
  - From the edge that samples start to the edge that enters DONE: NUM_VECTORS*(SETTLE_CYCLES+1) cycles.
- start asserted during SETTLE/CAPTURE is ignored; no abort mechanism exists.
- Holding start high in DONE restarts immediately; software drops start to observe done.
- rst_n asserted mid-run returns immediately to reset values; the partial signature is lost.
- vec_cnt is 16 bits; no wrap is possible within the legal NUM_VECTORS range.
- The LFSR never reaches 0 from a nonzero seed. The MISR may be any value including 0.

Decomposition:
- Shared package alu_bist_pkg holds:
  - the state enum (IDLE, SETTLE, CAPTURE, DONE);
  - the polynomial constant 16'hB400;
  - the g() step function.
- One natural sub-module, galois16_step, is a register with a parallel XOR input.
  - It is instantiated twice: as the LFSR (parallel input 0) and as the MISR (parallel input {8'h00, dut_result}).

Test Plan:
- Reset check: after rst_n low -> stim_a=1, stim_b=E, stim_op=4, busy=0, done=0, pass=0, signature=0.
- First vector: start=1, SETTLE_CYCLES=1 -> at the first CAPTURE edge lfsr becomes 16'hE270, so the next vector is stim_a=0, stim_b=7, stim_op=2.
- Tied-zero result, GOLDEN_SIG=0, NUM_VECTORS=256, SETTLE_CYCLES=1 -> done exactly 512 cycles after start is sampled, signature=0, pass=1.
- dut_result tied 8'h01, NUM_VECTORS=2 -> signature=16'hB401 at DONE, pass=0 with GOLDEN_SIG=0. With NUM_VECTORS=1 -> signature=16'h0001.
- ena=0 for 10 cycles mid-SETTLE -> stim_*, signature and counters unchanged; DONE arrives 10 cycles later than nominal.
- rst_n pulsed at vector 100, then start again -> run restarts from seed; final signature equals an uninterrupted run.

Source files
------------

// File: rtl/alu_bist_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_bist_pkg
// Purpose  : Shared FSM states and Galois step for the ALU BIST driver.
// Revision : 1.0
// ============================================================================
package alu_bist_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_e;

  localparam logic [15:0] GALOIS_POLY = 16'hB400;

  // Right-shifting Galois step shared by the LFSR and the MISR.
  function automatic logic [15:0] galois_step(input logic [15:0] x);
    return x[0] ? ((x >> 1) ^ GALOIS_POLY) : (x >> 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/galois16_step.sv
`default_nettype none
// ============================================================================
// Module   : galois16_step
// Purpose  : 16-bit Galois shift register with parallel XOR input and load.
// Revision : 1.0
// ============================================================================
module galois16_step
  import alu_bist_pkg::*;
#(
  parameter logic [15:0] LOAD_VAL = 16'h0000,
  parameter int          OUT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [15:0]      par_i,
  output logic [OUT_W-1:0] state_o
);

  logic [15:0] state_q;
  logic [15:0] state_d;

  // Load takes priority so a run start always begins from a known value.
  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = LOAD_VAL;
    end else if (step_i) begin
      state_d = galois_step(state_q) ^ par_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD_VAL;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q[OUT_W-1:0];

endmodule
`default_nettype wire

// File: rtl/alu_bist_driver.sv
`default_nettype none
// ============================================================================
// Module   : alu_bist_driver
// Purpose  : LFSR stimulus generator and MISR compactor for the 4-bit ALU.
// Revision : 1.0
// ============================================================================
module alu_bist_driver
  import alu_bist_pkg::*;
#(
  parameter int unsigned NUM_VECTORS   = 256,
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1,
  parameter logic [15:0] GOLDEN_SIG    = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic        start,
  input  logic [7:0]  dut_result,
  output logic [3:0]  stim_a,
  output logic [3:0]  stim_b,
  output logic [2:0]  stim_op,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] signature
);

  localparam logic [15:0] LAST_VEC    = 16'(NUM_VECTORS - 1);
  localparam logic [3:0]  LAST_SETTLE = 4'(SETTLE_CYCLES - 1);

  state_e      state_q, state_d;
  logic [15:0] vec_cnt_q, vec_cnt_d;
  logic [3:0]  settle_cnt_q, settle_cnt_d;
  logic        pass_q, pass_d;

  logic        run_load;
  logic        do_capture;
  logic [10:0] lfsr_q;
  logic [15:0] misr_q;
  logic [15:0] dut_par;
  logic [15:0] misr_next;

  assign dut_par   = {8'h00, dut_result};
  // Needed here so pass can be registered from the value the MISR is about to take.
  assign misr_next = galois_step(misr_q) ^ dut_par;

  always_comb begin
    state_d      = state_q;
    vec_cnt_d    = vec_cnt_q;
    settle_cnt_d = settle_cnt_q;
    pass_d       = pass_q;
    run_load     = 1'b0;
    do_capture   = 1'b0;
    if (ena) begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            run_load     = 1'b1;
            vec_cnt_d    = 16'd0;
            settle_cnt_d = 4'd0;
            pass_d       = 1'b0;
            state_d      = SETTLE;
          end
        end
        SETTLE: begin
          settle_cnt_d = settle_cnt_q + 4'd1;
          if (settle_cnt_q == LAST_SETTLE) begin
            state_d = CAPTURE;
          end
        end
        CAPTURE: begin
          do_capture   = 1'b1;
          settle_cnt_d = 4'd0;
          if (vec_cnt_q == LAST_VEC) begin
            state_d = DONE;
            pass_d  = (misr_next == GOLDEN_SIG);
          end else begin
            vec_cnt_d = vec_cnt_q + 16'd1;
            state_d   = SETTLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      vec_cnt_q    <= 16'd0;
      settle_cnt_q <= 4'd0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      vec_cnt_q    <= vec_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      pass_q       <= pass_d;
    end
  end

  // Only the low 11 LFSR bits drive stimulus; the full 16-bit state stays inside.
  galois16_step #(
    .LOAD_VAL (LFSR_SEED),
    .OUT_W    (11)
  ) u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (run_load),
    .step_i  (do_capture),
    .par_i   (16'h0000),
    .state_o (lfsr_q)
  );

  galois16_step #(
    .LOAD_VAL (16'h0000),
    .OUT_W    (16)
  ) u_misr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (run_load),
    .step_i  (do_capture),
    .par_i   (dut_par),
    .state_o (misr_q)
  );

  assign stim_a    = lfsr_q[3:0];
  assign stim_b    = lfsr_q[7:4];
  assign stim_op   = lfsr_q[10:8];
  assign busy      = (state_q == SETTLE) || (state_q == CAPTURE);
  assign done      = (state_q == DONE);
  assign pass      = pass_q;
  assign signature = misr_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_bist_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_bist_driver
// Purpose  : Self-checking bench for alu_bist_driver against a vector-level model.
// Revision : 1.0
// ============================================================================
module tb_alu_bist_driver;

  localparam int          N    = 256;
  localparam int          S    = 1;
  localparam int          NCYC = N * (S + 1);
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  logic rst_n;
  logic ena;
  logic start;
  logic force_zero;
  logic [7:0] mask;
  logic [7:0] res_main;
  logic [7:0] res_one;

  logic [3:0]  a, b, a2, b2, a1, b1;
  logic [2:0]  op, op2, op1;
  logic        busy, done, pass, busy2, done2, pass2, busy1, done1, pass1;
  logic [15:0] sig, sig2, sig1;

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  // Behavioural stand-in for the ALU under test.
  function automatic logic [7:0] alu_fn(input logic [3:0] x, input logic [3:0] y, input logic [2:0] o);
    case (o)
      3'd0:    return 8'(x) + 8'(y);
      3'd1:    return 8'(x) - 8'(y);
      3'd2:    return {4'h0, x & y};
      3'd3:    return {4'h0, x | y};
      3'd4:    return {4'h0, x ^ y};
      3'd5:    return {x, y};
      3'd6:    return 8'(x) * 8'(y);
      default: return {y, ~x};
    endcase
  endfunction

  function automatic logic [15:0] gstep(input logic [15:0] x);
    return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
  endfunction

  function automatic logic [7:0] model_res(input logic [15:0] l);
    return force_zero ? 8'h00 : (alu_fn(l[3:0], l[7:4], l[10:8]) ^ mask);
  endfunction

  always_comb res_main = force_zero ? 8'h00 : (alu_fn(a, b, op) ^ mask);
  assign res_one = 8'h01;

  alu_bist_driver #(.NUM_VECTORS(N), .SETTLE_CYCLES(S), .LFSR_SEED(SEED), .GOLDEN_SIG(16'h0000)) u_dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .dut_result(res_main),
    .stim_a(a), .stim_b(b), .stim_op(op), .busy(busy), .done(done), .pass(pass), .signature(sig)
  );

  alu_bist_driver #(.NUM_VECTORS(2), .SETTLE_CYCLES(1), .LFSR_SEED(SEED), .GOLDEN_SIG(16'h0000)) u_n2 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .dut_result(res_one),
    .stim_a(a2), .stim_b(b2), .stim_op(op2), .busy(busy2), .done(done2), .pass(pass2), .signature(sig2)
  );

  alu_bist_driver #(.NUM_VECTORS(1), .SETTLE_CYCLES(3), .LFSR_SEED(SEED), .GOLDEN_SIG(16'h0001)) u_n1 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .dut_result(res_one),
    .stim_a(a1), .stim_b(b1), .stim_op(op1), .busy(busy1), .done(done1), .pass(pass1), .signature(sig1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_stim_a"}, 32'(a), 32'h1);
    check({tag, "_stim_b"}, 32'(b), 32'hE);
    check({tag, "_stim_op"}, 32'(op), 32'h4);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_done"}, 32'(done), 32'h0);
    check({tag, "_pass"}, 32'(pass), 32'h0);
    check({tag, "_sig"}, 32'(sig), 32'h0);
  endtask

  // One run of the main DUT. Expected stimulus/signature advance by one vector
  // every S+1 enabled cycles; disabled cycles must change nothing.
  task automatic run(input int stall_pct, input int block_at, input int abort_at,
                     input bit first_chk, input bit rand_start);
    logic [15:0] m_lfsr, m_misr;
    int en_cnt, cyc, off;
    bit ena_now;
    m_lfsr = SEED;
    m_misr = 16'h0000;
    en_cnt = 0;
    cyc    = 0;
    off    = 0;
    ena    = 1'b1;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    while (en_cnt < NCYC && cyc < 4 * NCYC + 100) begin
      check("run_busy", 32'(busy), 32'h1);
      check("run_done", 32'(done), 32'h0);
      check("run_pass", 32'(pass), 32'h0);
      check("run_stim", 32'({a, b, op}), 32'({m_lfsr[3:0], m_lfsr[7:4], m_lfsr[10:8]}));
      check("run_sig", 32'(sig), 32'(m_misr));
      if (first_chk && en_cnt == 2) begin
        check("vec1_stim_a", 32'(a), 32'h0);
        check("vec1_stim_b", 32'(b), 32'h7);
        check("vec1_stim_op", 32'(op), 32'h2);
      end
      if (abort_at >= 0 && en_cnt == abort_at) return;
      if (block_at >= 0 && cyc >= block_at && cyc < block_at + 10) ena_now = 1'b0;
      else ena_now = ($urandom_range(99) >= 32'(stall_pct));
      ena   = ena_now;
      start = rand_start && ($urandom_range(3) == 0);
      tick();
      cyc++;
      if (ena_now) begin
        en_cnt++;
        if (en_cnt % (S + 1) == 0) begin
          m_misr = gstep(m_misr) ^ {8'h00, model_res(m_lfsr)};
          m_lfsr = gstep(m_lfsr);
        end
      end else begin
        off++;
      end
    end
    ena   = 1'b1;
    start = 1'b0;
    if (en_cnt < NCYC) begin
      check("run_timeout", 32'(en_cnt), 32'(NCYC));
    end else begin
      check("end_done", 32'(done), 32'h1);
      check("end_busy", 32'(busy), 32'h0);
      check("end_sig", 32'(sig), 32'(m_misr));
      check("end_pass", 32'(pass), 32'(m_misr == 16'h0000));
      check("end_latency", 32'(cyc), 32'(NCYC + off));
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    ena        = 1'b1;
    start      = 1'b0;
    force_zero = 1'b1;
    mask       = 8'h00;
    tick(); tick(); tick();
    check_reset_outputs("reset");
    check("reset_n2_done", 32'(done2), 32'h0);
    check("reset_n1_sig", 32'(sig1), 32'h0);

    rst_n = 1'b1;
    tick(); tick(); tick();
    check("idle_busy", 32'(busy), 32'h0);
    check("idle_done", 32'(done), 32'h0);
    check("idle_stim_a", 32'(a), 32'h1);

    // Tied-zero result, no stalls: done exactly NCYC cycles after start.
    run(0, -1, -1, 1'b1, 1'b0);
    check("zero_run_sig", 32'(sig), 32'h0);
    check("zero_run_pass", 32'(pass), 32'h1);

    check("n2_done", 32'(done2), 32'h1);
    check("n2_sig", 32'(sig2), 32'hB401);
    check("n2_pass", 32'(pass2), 32'h0);
    check("n1_done", 32'(done1), 32'h1);
    check("n1_sig", 32'(sig1), 32'h0001);
    check("n1_pass", 32'(pass1), 32'h1);

    // ena low in DONE freezes it even with start high.
    ena   = 1'b0;
    start = 1'b1;
    tick(); tick(); tick();
    check("frozen_done", 32'(done), 32'h1);
    check("frozen_busy", 32'(busy), 32'h0);
    check("frozen_pass", 32'(pass), 32'h1);
    check("frozen_sig", 32'(sig), 32'h0);

    force_zero = 1'b0;
    mask = 8'($urandom());
    run(20, -1, -1, 1'b0, 1'b1);

    mask = 8'($urandom());
    run(0, 100, -1, 1'b0, 1'b0);

    mask = 8'($urandom());
    run(30, -1, -1, 1'b0, 1'b1);

    // Asynchronous reset at vector 100, then a clean rerun from the seed.
    mask = 8'($urandom());
    run(0, -1, 200, 1'b0, 1'b0);
    start = 1'b0;
    ena   = 1'b1;
    rst_n = 1'b0;
    #2;
    check_reset_outputs("midrun_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    check("post_reset_idle", 32'(busy), 32'h0);
    run(0, -1, -1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
`default_nettype wire
